// File: rtl/mips_dmem_responder.sv
// Data-side responder for the multicycle MIPS core: one load/store at a time
// over req/ack, served from a word RAM at BASE_ADDR or an 8-bit GPIO register.
module mips_dmem_responder #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter logic [31:0] GPIO_ADDR   = 32'h1001_0400,
  parameter int          WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ack,
  output logic                  err,
  output logic                  busy,
  output logic [7:0]            gpio_data_out
);

  localparam int          DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES - 1);
  localparam bit          NO_WAIT   = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_r;
  logic [3:0]            cnt_r;
  logic                  we_r;
  logic [31:0]           addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  pend_err_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  ack_r;
  logic                  err_r;
  logic                  busy_r;
  logic [7:0]            gpio_r;
  logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

  logic                  acc_we_s;
  logic [31:0]           acc_addr_s;
  logic [DATA_WIDTH-1:0] acc_wdata_s;
  logic                  ram_hit_s;
  logic                  gpio_hit_s;
  logic                  bad_s;
  logic [ADDR_WIDTH-1:0] idx_s;
  logic                  commit_s;

  function automatic logic ram_hit(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (off < RAM_BYTES);
  endfunction

  // Select the access fields (live inputs when committing straight from IDLE) and decode them.
  always_comb begin
    acc_we_s    = 1'b0;
    acc_addr_s  = 32'h0000_0000;
    acc_wdata_s = '0;
    if (state_r == S_IDLE) begin
      acc_we_s    = we;
      acc_addr_s  = addr;
      acc_wdata_s = wdata;
    end else begin
      acc_we_s    = we_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
    end
    ram_hit_s  = ram_hit(acc_addr_s);
    gpio_hit_s = (acc_addr_s == GPIO_ADDR);
    bad_s      = (acc_addr_s[1:0] != 2'b00) || !(ram_hit_s || gpio_hit_s);
    idx_s      = ADDR_WIDTH'((acc_addr_s - BASE_ADDR) >> 2);
  end

  // Commit fires on the edge that moves the FSM into RESP.
  always_comb begin
    commit_s = 1'b0;
    case (state_r)
      S_IDLE:  commit_s = req && NO_WAIT;
      S_WAIT:  commit_s = (cnt_r == 4'd0);
      default: commit_s = 1'b0;
    endcase
  end

  // Handshake FSM with registered outputs; ack/err trail RESP by one edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= 4'd0;
      we_r       <= 1'b0;
      addr_r     <= 32'h0000_0000;
      wdata_r    <= '0;
      pend_err_r <= 1'b0;
      rdata_r    <= '0;
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
      gpio_r     <= 8'h00;
    end else begin
      ack_r <= (state_r == S_RESP);
      err_r <= (state_r == S_RESP) && pend_err_r;
      case (state_r)
        S_IDLE: begin
          if (req) begin
            we_r    <= we;
            addr_r  <= addr;
            wdata_r <= wdata;
            busy_r  <= 1'b1;
            cnt_r   <= WAIT_INIT;
            if (NO_WAIT) begin
              state_r <= S_RESP;
            end else begin
              state_r <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= S_RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_RESP: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
      if (commit_s) begin
        pend_err_r <= bad_s;
        if (bad_s || acc_we_s) begin
          rdata_r <= '0;
        end else if (gpio_hit_s) begin
          rdata_r <= {{(DATA_WIDTH-8){1'b0}}, gpio_r};
        end else begin
          rdata_r <= mem_r[idx_s];
        end
        if (!bad_s && acc_we_s && gpio_hit_s) begin
          gpio_r <= acc_wdata_s[7:0];
        end
      end
    end
  end

  // RAM is never cleared; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (reset && commit_s && acc_we_s && !bad_s && ram_hit_s) begin
      mem_r[idx_s] <= acc_wdata_s;
    end
  end

  assign rdata         = rdata_r;
  assign ack           = ack_r;
  assign err           = err_r;
  assign busy          = busy_r;
  assign gpio_data_out = gpio_r;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: three instances (0, 1 and 3 wait states) share
// stimulus and are checked every cycle against a transaction-timing model.
module tb_mips_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata_o [3];
  logic        ack_o   [3];
  logic        err_o   [3];
  logic        busy_o  [3];
  logic [7:0]  gpio_o  [3];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit b2b    = 1'b0;
  int last_ack [3];

  mips_dmem_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_o[0]), .ack(ack_o[0]), .err(err_o[0]), .busy(busy_o[0]), .gpio_data_out(gpio_o[0]));
  mips_dmem_responder #(.WAIT_STATES(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_o[1]), .ack(ack_o[1]), .err(err_o[1]), .busy(busy_o[1]), .gpio_data_out(gpio_o[1]));
  mips_dmem_responder #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_o[2]), .ack(ack_o[2]), .err(err_o[2]), .busy(busy_o[2]), .gpio_data_out(gpio_o[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          ws_k       [3] = '{0, 1, 3};
  int          period_lit [3] = '{2, 3, 5};
  int          n_edge = 0;
  bit          inf    [3];
  int          cap    [3];
  bit          t_we   [3];
  logic [31:0] t_addr [3];
  logic [31:0] t_wd   [3];
  bit          r_err  [3];
  logic [31:0] mmem   [3][256];
  bit          mknown [3][256];
  bit          e_ack  [3];
  bit          e_err  [3];
  bit          e_busy [3];
  bit          e_rdk  [3];
  logic [31:0] e_rd   [3];
  logic [7:0]  e_gpio [3];

  always @(posedge clk) begin : model
    bit          was_free;
    bit          is_ram;
    bit          is_gpio;
    bit          bad;
    int          idx;
    logic [31:0] a;
    n_edge++;
    for (int k = 0; k < 3; k++) begin
      if (!reset) begin
        inf[k] = 1'b0; e_ack[k] = 1'b0; e_err[k] = 1'b0; e_busy[k] = 1'b0;
        e_rd[k] = 32'h0; e_rdk[k] = 1'b1; e_gpio[k] = 8'h00;
      end else begin
        e_ack[k] = 1'b0;
        e_err[k] = 1'b0;
        was_free = !inf[k];
        if (inf[k] && n_edge == cap[k] + ws_k[k] + 1) begin
          e_ack[k] = 1'b1;
          e_err[k] = r_err[k];
          inf[k]   = 1'b0;
        end
        if (was_free && req) begin
          inf[k] = 1'b1; cap[k] = n_edge;
          t_we[k] = we; t_addr[k] = addr; t_wd[k] = wdata;
        end
        if (inf[k] && n_edge == cap[k] + ws_k[k]) begin
          a       = t_addr[k];
          is_ram  = (a >= 32'h1001_0000) && (a < 32'h1001_0400);
          is_gpio = (a == 32'h1001_0400);
          bad     = (a % 4 != 0) || !(is_ram || is_gpio);
          idx     = int'((a - 32'h1001_0000) / 4);
          r_err[k] = bad;
          e_rdk[k] = 1'b1;
          if (bad || t_we[k]) e_rd[k] = 32'h0;
          if (!bad && t_we[k] && is_ram) begin
            mmem[k][idx] = t_wd[k]; mknown[k][idx] = 1'b1;
          end
          if (!bad && t_we[k] && is_gpio) e_gpio[k] = t_wd[k][7:0];
          if (!bad && !t_we[k] && is_ram) begin
            e_rd[k] = mmem[k][idx]; e_rdk[k] = mknown[k][idx];
          end
          if (!bad && !t_we[k] && is_gpio) e_rd[k] = {24'h0, e_gpio[k]};
        end
        e_busy[k] = inf[k];
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("ack[%0d]", k),  32'(ack_o[k]),  32'(e_ack[k]));
        chk($sformatf("err[%0d]", k),  32'(err_o[k]),  32'(e_err[k]));
        chk($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(e_busy[k]));
        chk($sformatf("gpio[%0d]", k), 32'(gpio_o[k]), 32'(e_gpio[k]));
        if (e_rdk[k]) chk($sformatf("rdata[%0d]", k), rdata_o[k], e_rd[k]);
        if (b2b && ack_o[k]) begin
          if (last_ack[k] >= 0)
            chk($sformatf("ack_period[%0d]", k), 32'(n_edge - last_ack[k]), 32'(period_lit[k]));
          last_ack[k] = n_edge;
        end
      end
    end
  end

  // One transfer on the 1-wait-state instance; lat counts edges from capture to ack.
  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input bit toggle,
                      output logic [31:0] rd, output bit e, output int lat, output logic [7:0] g);
    int guard;
    bit got;
    guard = 0;
    @(negedge clk);
    while (busy_o[1] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    if (toggle) addr = a ^ 32'h0000_0004;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (ack_o[1]) got = 1'b1;
    end
    req = 1'b0;
    rd = rdata_o[1];
    e  = err_o[1];
    g  = gpio_o[1];
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout addr=%0h got=no_ack expected=ack", a);
    end
  endtask

  logic [31:0] rd;
  bit          e;
  int          lat;
  logic [7:0]  g;
  int          acks;
  logic [31:0] pick [10] = '{32'h1001_0000, 32'h1001_0004, 32'h1001_0008, 32'h1001_000C,
                             32'h1001_03FC, 32'h1001_0400, 32'h1001_0002, 32'h2000_0000,
                             32'h1001_0404, 32'h1000_FFFC};

  initial begin
    reset = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h1001_0000; wdata = 32'h0;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_ack",   32'(ack_o[1]),  32'h0);
    chk("reset_busy",  32'(busy_o[1]), 32'h0);
    chk("reset_rdata", rdata_o[1],     32'h0);
    chk("reset_gpio",  32'(gpio_o[1]), 32'h0);
    reset = 1'b1; req = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", 32'(busy_o[1]), 32'h0);

    xfer(1'b1, 32'h1001_0000, 32'h0000_002C, 1'b0, rd, e, lat, g);
    chk("sw_latency", 32'(lat), 32'd2);
    chk("sw_err", 32'(e), 32'h0);
    xfer(1'b0, 32'h1001_0000, 32'h0, 1'b0, rd, e, lat, g);
    chk("lw_base", rd, 32'h0000_002C);
    xfer(1'b1, 32'h1001_0004, 32'd20, 1'b0, rd, e, lat, g);
    xfer(1'b0, 32'h1001_0004, 32'h0, 1'b0, rd, e, lat, g);
    chk("lw_word1", rd, 32'd20);

    xfer(1'b1, 32'h1001_0400, 32'hDEAD_BEA5, 1'b0, rd, e, lat, g);
    chk("gpio_at_ack", 32'(g), 32'h0000_00A5);
    xfer(1'b0, 32'h1001_0400, 32'h0, 1'b0, rd, e, lat, g);
    chk("lw_gpio", rd, 32'h0000_00A5);

    xfer(1'b0, 32'h1001_0002, 32'h0, 1'b0, rd, e, lat, g);
    chk("misaligned_err", 32'(e), 32'h1);
    chk("misaligned_rdata", rd, 32'h0);
    xfer(1'b1, 32'h2000_0000, 32'h1111_2222, 1'b0, rd, e, lat, g);
    chk("unmapped_err", 32'(e), 32'h1);
    chk("unmapped_gpio", 32'(g), 32'h0000_00A5);
    xfer(1'b0, 32'h1001_0000, 32'h0, 1'b0, rd, e, lat, g);
    chk("lw_after_unmapped", rd, 32'h0000_002C);

    xfer(1'b1, 32'h1001_03FC, 32'hA5A5_0001, 1'b0, rd, e, lat, g);
    chk("top_word_err", 32'(e), 32'h0);
    xfer(1'b0, 32'h1001_03FC, 32'h0, 1'b0, rd, e, lat, g);
    chk("top_word_lw", rd, 32'hA5A5_0001);
    xfer(1'b0, 32'h1001_0404, 32'h0, 1'b0, rd, e, lat, g);
    chk("past_gpio_err", 32'(e), 32'h1);

    xfer(1'b0, 32'h1001_0000, 32'h0, 1'b1, rd, e, lat, g);
    chk("addr_toggle", rd, 32'h0000_002C);

    // Abort a store with reset while it sits in WAIT.
    xfer(1'b1, 32'h1001_0008, 32'h0000_0077, 1'b0, rd, e, lat, g);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h1001_0008; wdata = 32'h0000_0055;
    @(posedge clk);
    #1;
    req = 1'b0; reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    acks = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ack_o[1]) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'h0);
    xfer(1'b0, 32'h1001_0008, 32'h0, 1'b0, rd, e, lat, g);
    chk("abort_keeps_old", rd, 32'h0000_0077);

    // Continuous request: ack period is WAIT_STATES+2.
    repeat (10) @(negedge clk);
    for (int k = 0; k < 3; k++) last_ack[k] = -1;
    b2b = 1'b1;
    req = 1'b1; we = 1'b0; addr = 32'h1001_0000;
    repeat (30) @(negedge clk);
    req = 1'b0;
    repeat (8) @(negedge clk);
    b2b = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      req   = ($urandom_range(0, 2) != 0);
      we    = $urandom_range(0, 1) == 1;
      addr  = pick[$urandom_range(0, 9)];
      wdata = $urandom;
      reset = ($urandom_range(0, 149) != 0);
    end
    @(negedge clk);
    req = 1'b0; reset = 1'b1;
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_dmem_responder.md
# mips_dmem_responder

Data-side responder for the multicycle MIPS core. It is the far end of the core's load/store path: it accepts one `sw`/`lw` request at a time over a req/ack handshake. Requests are served from a word-addressed data RAM mapped at 0x1001_0000, or from an 8-bit GPIO output register. Latency is fixed and programmable through wait states, so the core's STORE/LOAD states can be exercised against a realistic slow memory.

## Interface
Parameters:
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 8, RAM index bits; RAM depth = 2^ADDR_WIDTH words
- BASE_ADDR, 32'h1001_0000, byte address of RAM word 0
- GPIO_ADDR, 32'h1001_0400, byte address of the GPIO register
- WAIT_STATES, 1, extra cycles between request capture and ack (0..15)

Ports:
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  synchronous, active-low reset
- req  input  1  request valid from core
- we  input  1  1 = store (`sw`), 0 = load (`lw`); captured with req
- addr  input  32  byte address; captured with req
- wdata  input  DATA_WIDTH  store data; captured with req
- rdata  output  DATA_WIDTH  load data; valid while ack=1
- ack  output  1  one-cycle completion pulse
- err  output  1  qualifies ack: unmapped or misaligned access
- busy  output  1  high in WAIT and RESP
- gpio_data_out  output  8  GPIO register contents

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if req=1 at a rising edge, capture we/addr/wdata.
  - Go to WAIT with wait counter = WAIT_STATES-1.
  - If WAIT_STATES=0, go straight to RESP.
- WAIT: decrement the counter each cycle. When the counter = 0, go to RESP.
- Commit happens on the edge that enters RESP:
  - Store to RAM: RAM[(addr-BASE_ADDR)>>2] <= wdata.
  - Store to GPIO: gpio_data_out <= wdata[7:0].
  - Load from RAM: rdata <= RAM word.
  - Load from GPIO: rdata <= {24'b0, gpio_data_out}.
  - Store: rdata <= 0.
- RESP: ack=1 for exactly one cycle, then go to IDLE unconditionally.
- Address decode uses the captured address:
  - RAM hit: BASE_ADDR ≤ addr < BASE_ADDR + 4·2^ADDR_WIDTH.
  - GPIO hit: addr == GPIO_ADDR.
  - Anything else is unmapped.
- addr[1:0] ≠ 0, or unmapped: err=1 with ack, no state change, rdata=0.
- req and the captured fields are ignored outside IDLE. Changing addr mid-transaction has no effect.
- req still high in the IDLE cycle after RESP starts a new transaction. The core must drop req when it sees ack.
- Reset values: state=IDLE, ack=0, err=0, busy=0, rdata=0, gpio_data_out=0. RAM contents are not cleared.
- Reset asserted in WAIT aborts the transaction: no RAM or GPIO write, no ack.
- Reset in RESP: the commit has already happened, and ack drops on the reset edge.

## Timing
- Request sampled at edge E; ack high in the cycle after edge E+1+WAIT_STATES. Total latency = WAIT_STATES+1 cycles from capture to ack.
- Minimum spacing between request captures: WAIT_STATES+2 cycles, because of the mandatory IDLE cycle.
- rdata, err and gpio_data_out are registered outputs, with no combinational path from inputs.
- Write then read to the same address: the read returns the new value, since commits are sequential.
- busy rises on the capture edge and falls on the edge leaving RESP.

## Test plan
- Reset and idle:
  - Hold reset=0 for 2 cycles while req=1 -> ack=0, err=0, busy=0, rdata=0, gpio_data_out=0.
  - Release reset with req=0 -> remains idle.
- Store/load round trip, WAIT_STATES=1:
  - sw 0x0000_002C to 0x1001_0000 -> ack exactly 2 cycles after capture, err=0.
  - Then lw from 0x1001_0000 -> rdata=0x0000_002C on ack.
  - lw from 0x1001_0004 after sw 20 there -> rdata=20.
- GPIO:
  - sw 0xDEAD_BEA5 to 0x1001_0400 -> gpio_data_out=0xA5 from the ack cycle onward.
  - lw from 0x1001_0400 -> rdata=0x0000_00A5.
- Errors:
  - lw 0x1001_0002 -> ack with err=1, rdata=0.
  - sw 0x2000_0000 -> ack with err=1, no RAM/GPIO change; a subsequent lw 0x1001_0000 still returns the old value.
  - Top word 0x1001_03FC is accepted; 0x1001_0404 sets err.
- Back-to-back and latency sweep:
  - Hold req=1 continuously with WAIT_STATES=0 -> ack every 2nd cycle.
  - With WAIT_STATES=3 -> ack every 5th cycle.
  - Toggling addr during WAIT does not alter the result.
- Reset mid-operation:
  - Assert reset during WAIT of sw 0x55 to 0x1001_0008 -> no ack.
  - After release, lw 0x1001_0008 returns the prior contents, not 0x55.
